alarm_display: RTL and testbench

- Reader side of the countdown-timer interface.
- Consumes the timer's 17-bit remaining-seconds value and its three flash flags, and converts the seconds to HH:MM:SS BCD with an iterative subtract FSM.
- Drives six active-low 7-segment digits and blanks flashing fields at a programmable blink rate.
- Sits between the countdown timer and the board HEX displays.

---
 rtl/alarm_display_pkg.sv | 35 +++
 rtl/alarm_display_seven_seg_dec.sv | 18 +
 rtl/alarm_display.sv | 235 +++++++++++++++++++++++
 tb/tb_alarm_display.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alarm_display_pkg.sv
// Shared types and constants for the HH:MM:SS alarm display.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package alarm_display_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HRS,
        S_MINS,
        S_SPLIT,
        S_DONE
    } state_e;

    localparam int SEC_PER_HR  = 3600;
    localparam int SEC_PER_MIN = 60;
    localparam int DEC_BASE    = 10;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry [d] holds the glyph for decimal digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] d);
        logic [6:0] r;
        r = SEG_BLANK;
        if (d <= 4'd9) begin
            r = SEG_TABLE[d];
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_display_seven_seg_dec.sv
// One BCD digit to an active-low 7-segment glyph.
// Codes above 9 and a high blank input both give an unlit digit.
module seven_seg_dec
    import alarm_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            seg_o = seg_lookup(bcd_i);
        end
    end

endmodule

// File: rtl/alarm_display.sv
// Converts countdown seconds to HH:MM:SS BCD by iterative subtraction
// and drives six active-low digits with per-field blinking.
module alarm_display
    import alarm_display_pkg::*;
#(
    parameter int BLINK_HALF = 25000000,
    parameter int MAX_SEC    = 86399
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] sec_in,
    input  logic        flash_hh,
    input  logic        flash_mm,
    input  logic        flash_ss,
    output logic [7:0]  hh_bcd,
    output logic [7:0]  mm_bcd,
    output logic [7:0]  ss_bcd,
    output logic [41:0] seg,
    output logic        conv_done
);

    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

    localparam logic [16:0] SAT_W = 17'(MAX_SEC);
    localparam logic [16:0] HR_W  = 17'(SEC_PER_HR);
    localparam logic [16:0] MIN_W = 17'(SEC_PER_MIN);
    localparam logic [4:0]  TEN5  = 5'(DEC_BASE);
    localparam logic [5:0]  TEN6  = 6'(DEC_BASE);

    state_e state_q, state_d;

    logic [16:0] work_q, work_d;
    logic [16:0] last_q, last_d;
    logic        force_q, force_d;
    logic [4:0]  hrs_q, hrs_d;
    logic [5:0]  min_q, min_d;
    logic [5:0]  sec_q, sec_d;
    logic [3:0]  ht_q, ht_d;
    logic [3:0]  mt_q, mt_d;
    logic [3:0]  st_q, st_d;
    logic [7:0]  hh_q, hh_d;
    logic [7:0]  mm_q, mm_d;
    logic [7:0]  ss_q, ss_d;
    logic        done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;

    logic hr_ge, min_ge, split_fin, conv_req;
    logic ld, h_sub, m_sub, s_take, sp_step, publish;

    assign hr_ge     = (work_q >= HR_W);
    assign min_ge    = (work_q >= MIN_W);
    assign split_fin = (hrs_q < TEN5) && (min_q < TEN6) && (sec_q < TEN6);
    assign conv_req  = force_q || (sec_in != last_q);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (conv_req) state_d = S_LOAD;
            S_LOAD:  state_d = S_HRS;
            S_HRS:   if (!hr_ge) state_d = S_MINS;
            S_MINS:  if (!min_ge) state_d = S_SPLIT;
            S_SPLIT: if (split_fin) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: datapath strobes
    always_comb begin
        ld      = 1'b0;
        h_sub   = 1'b0;
        m_sub   = 1'b0;
        s_take  = 1'b0;
        sp_step = 1'b0;
        publish = 1'b0;
        unique case (state_q)
            S_IDLE:  ;
            S_LOAD:  ld = 1'b1;
            S_HRS:   h_sub = hr_ge;
            S_MINS: begin
                m_sub  = min_ge;
                s_take = !min_ge;
            end
            S_SPLIT: sp_step = !split_fin;
            S_DONE:  publish = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        work_d  = work_q;
        last_d  = last_q;
        force_d = force_q;
        hrs_d   = hrs_q;
        min_d   = min_q;
        sec_d   = sec_q;
        ht_d    = ht_q;
        mt_d    = mt_q;
        st_d    = st_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        done_d  = 1'b0;

        if (ld) begin
            work_d  = (sec_in > SAT_W) ? SAT_W : sec_in;
            last_d  = sec_in;
            force_d = 1'b0;
            hrs_d   = '0;
            min_d   = '0;
            sec_d   = '0;
            ht_d    = '0;
            mt_d    = '0;
            st_d    = '0;
        end

        if (h_sub) begin
            work_d = work_q - HR_W;
            hrs_d  = hrs_q + 5'd1;
        end

        if (m_sub) begin
            work_d = work_q - MIN_W;
            min_d  = min_q + 6'd1;
        end

        // Remainder below one minute is the seconds field.
        if (s_take) begin
            sec_d = work_q[5:0];
        end

        if (sp_step) begin
            if (hrs_q >= TEN5) begin
                hrs_d = hrs_q - TEN5;
                ht_d  = ht_q + 4'd1;
            end
            if (min_q >= TEN6) begin
                min_d = min_q - TEN6;
                mt_d  = mt_q + 4'd1;
            end
            if (sec_q >= TEN6) begin
                sec_d = sec_q - TEN6;
                st_d  = st_q + 4'd1;
            end
        end

        if (publish) begin
            hh_d   = {ht_q, hrs_q[3:0]};
            mm_d   = {mt_q, min_q[3:0]};
            ss_d   = {st_q, sec_q[3:0]};
            done_d = 1'b1;
        end
    end

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = !phase_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_q  <= '0;
            last_q  <= '0;
            force_q <= 1'b1;
            hrs_q   <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            ht_q    <= '0;
            mt_q    <= '0;
            st_q    <= '0;
            hh_q    <= '0;
            mm_q    <= '0;
            ss_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            work_q  <= work_d;
            last_q  <= last_d;
            force_q <= force_d;
            hrs_q   <= hrs_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            ht_q    <= ht_d;
            mt_q    <= mt_d;
            st_q    <= st_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign hh_bcd    = hh_q;
    assign mm_bcd    = mm_q;
    assign ss_bcd    = ss_q;
    assign conv_done = done_q;

    logic [5:0][3:0] dig;
    logic [5:0]      blank;
    logic            bh, bm, bs;

    assign bh    = flash_hh && !phase_q;
    assign bm    = flash_mm && !phase_q;
    assign bs    = flash_ss && !phase_q;
    assign dig   = {hh_q, mm_q, ss_q};
    assign blank = {bh, bh, bm, bm, bs, bs};

    for (genvar g = 0; g < 6; g++) begin : g_dig
        seven_seg_dec u_dec (
            .bcd_i   (dig[g]),
            .blank_i (blank[g]),
            .seg_o   (seg[g*7 +: 7])
        );
    end

endmodule

// File: tb/tb_alarm_display.sv
// Scoreboard bench for alarm_display: stimulus pushes expected BCD,
// a monitor pops and compares on every conv_done pulse.
module tb_alarm_display;

    logic        clk;
    logic        reset;
    logic [16:0] sec_in;
    logic        flash_hh, flash_mm, flash_ss;
    logic [7:0]  hh_bcd, mm_bcd, ss_bcd;
    logic [41:0] seg;
    logic        conv_done;

    int n_chk  = 0;
    int n_fail = 0;

    logic [23:0] exp_q[$];

    localparam logic [13:0] MM_SHOW  = {7'h79, 7'h24};
    localparam logic [13:0] MM_BLANK = 14'h3FFF;

    alarm_display #(
        .BLINK_HALF (4),
        .MAX_SEC    (86399)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sec_in    (sec_in),
        .flash_hh  (flash_hh),
        .flash_mm  (flash_mm),
        .flash_ss  (flash_ss),
        .hh_bcd    (hh_bcd),
        .mm_bcd    (mm_bcd),
        .ss_bcd    (ss_bcd),
        .seg       (seg),
        .conv_done (conv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every conv_done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && conv_done) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_conv_done: got %h%h%h expected none",
                         hh_bcd, mm_bcd, ss_bcd);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("conv_bcd", {hh_bcd, mm_bcd, ss_bcd}, e);
            end
        end
    end

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (conv_done) got = 1'b1;
        end
        check(name, got, 1'b1);
    endtask

    initial begin
        logic [13:0] mm_s[24];
        logic [13:0] ref_v, alt_v, e_v;
        int f;
        bit steady;

        reset    = 1'b1;
        sec_in   = 17'd0;
        flash_hh = 1'b0;
        flash_mm = 1'b0;
        flash_ss = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_bcd", {hh_bcd, mm_bcd, ss_bcd}, 24'h0);
        check("rst_done", conv_done, 1'b0);
        check("rst_seg", seg, {6{7'h40}});

        exp_q.push_back(24'h000000);
        reset = 1'b0;
        wait_done("lat_zero");
        check("zero_seg", seg, {6{7'h40}});

        sec_in = 17'd3661;
        exp_q.push_back(24'h010101);
        wait_done("lat_3661");
        check("units_3661", {seg[34:28], seg[20:14], seg[6:0]},
              {7'h79, 7'h79, 7'h79});

        sec_in = 17'd86399;
        exp_q.push_back(24'h235959);
        wait_done("lat_86399");
        check("h_tens_seg", seg[41:35], 7'h24);

        sec_in = 17'd100000;
        exp_q.push_back(24'h235959);
        wait_done("lat_sat");

        sec_in = 17'd754;
        exp_q.push_back(24'h001234);
        wait_done("lat_754");
        check("mm_shown", seg[27:14], MM_SHOW);

        flash_mm = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            mm_s[i] = seg[27:14];
            check("blink_hh_ss", {seg[41:28], seg[13:0]},
                  {7'h40, 7'h40, 7'h30, 7'h19});
        end
        f = 0;
        for (int i = 1; i < 24; i++) begin
            if (f == 0 && mm_s[i] != mm_s[0]) f = i;
        end
        check("blink_first_edge", (f >= 1 && f <= 4), 1'b1);
        ref_v = mm_s[f];
        check("blink_code", (ref_v == MM_SHOW || ref_v == MM_BLANK), 1'b1);
        alt_v = (ref_v == MM_BLANK) ? MM_SHOW : MM_BLANK;
        for (int i = f; i < 24; i++) begin
            e_v = ((((i - f) / 4) % 2) == 0) ? ref_v : alt_v;
            check("blink_mm", mm_s[i], e_v);
        end

        flash_mm = 1'b0;
        steady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (seg[27:14] != MM_SHOW) steady = 1'b0;
        end
        check("noflash_steady", steady, 1'b1);

        sec_in = 17'd3661;
        exp_q.push_back(24'h010101);
        exp_q.push_back(24'h000059);
        repeat (3) @(negedge clk);
        sec_in = 17'd59;
        wait_done("lat_mid_first");
        wait_done("lat_mid_second");
        check("mid_final", {hh_bcd, mm_bcd, ss_bcd}, 24'h000059);

        sec_in = 17'd7200;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_bcd", {hh_bcd, mm_bcd, ss_bcd}, 24'h0);
        check("midrst_done", conv_done, 1'b0);
        check("midrst_seg", seg, {6{7'h40}});
        @(negedge clk);
        exp_q.push_back(24'h020000);
        reset = 1'b0;
        wait_done("lat_7200");

        repeat (20) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
